// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up applied at the end.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in_A,
  input  logic [XLEN-1:0] in_B,
  input  logic            flush,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] out
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] sr_q, sr_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   out_q, out_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_rem, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  // Sign flags and magnitudes of the incoming operands; |-2^(XLEN-1)| wraps to itself.
  always_comb begin
    a_neg = ((op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110))
            && in_A[XLEN-1];
    b_neg = ((op == 3'b001) || (op == 3'b100) || (op == 3'b110)) && in_B[XLEN-1];
    a_mag = a_neg ? -in_A : in_A;
    b_mag = b_neg ? -in_B : in_B;
  end

  // Datapath: sr_q holds {partial, multiplier} for mul and {remainder, quotient} for div.
  always_comb begin
    mul_sum  = {1'b0, sr_q[2*XLEN-1:XLEN]} + (sr_q[0] ? {1'b0, opnd_q} : '0);
    div_rem  = sr_q[2*XLEN-1:XLEN-1];
    div_diff = div_rem - {1'b0, opnd_q};
    prod_fix = neg_q ? -sr_q : sr_q;
    quot_fix = neg_q ? -sr_q[XLEN-1:0] : sr_q[XLEN-1:0];
    rem_fix  = neg_q ? -sr_q[2*XLEN-1:XLEN] : sr_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid && !flush) begin
          op_d  = op;
          // Remainder takes the dividend sign; everything else the sign product.
          neg_d = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
          cnt_d = '0;
          if (op[2]) begin
            sr_d   = {{XLEN{1'b0}}, a_mag};
            opnd_d = b_mag;
            if (in_B == '0) begin
              out_d   = op[1] ? in_A : '1;
              state_d = S_OUT;
            end else begin
              state_d = S_CALC;
            end
          end else begin
            sr_d    = {{XLEN{1'b0}}, b_mag};
            opnd_d  = a_mag;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          if (op_q[2]) begin
            if (!div_diff[XLEN]) sr_d = {div_diff[XLEN-1:0], sr_q[XLEN-2:0], 1'b1};
            else                 sr_d = {div_rem[XLEN-1:0], sr_q[XLEN-2:0], 1'b0};
          end else begin
            sr_d = {mul_sum, sr_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          if (op_q[2])                out_d = op_q[1] ? rem_fix : quot_fix;
          else if (op_q[1:0] == 2'b00) out_d = prod_fix[XLEN-1:0];
          else                        out_d = prod_fix[2*XLEN-1:XLEN];
          state_d = S_OUT;
        end
      end
      S_OUT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign ready = (state_q == S_OUT);
  assign out   = out_q;

endmodule
